// File: rtl/traffic_light_pkg.sv
// Shared lamp encodings, phase patterns and monitor states for the two-road traffic light.
package traffic_light_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    typedef struct packed {
        logic [2:0] light_1;
        logic [2:0] light_2;
    } lamp_pair_t;

    localparam lamp_pair_t PAT_P0 = {LAMP_GREEN,  LAMP_RED};
    localparam lamp_pair_t PAT_P1 = {LAMP_YELLOW, LAMP_RED};
    localparam lamp_pair_t PAT_P2 = {LAMP_RED,    LAMP_GREEN};
    localparam lamp_pair_t PAT_P3 = {LAMP_RED,    LAMP_YELLOW};

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        FIRST = 2'd1,
        TRACK = 2'd2
    } mon_state_t;

    localparam int DEF_GREEN_CYCLES  = 16;
    localparam int DEF_YELLOW_CYCLES = 6;

    // Odd phases are yellow, even phases are green.
    function automatic logic [7:0] req_dwell(input logic [1:0] p,
                                             input logic [7:0] green,
                                             input logic [7:0] yellow);
        return p[0] ? yellow : green;
    endfunction

endpackage

// File: rtl/traffic_light_pattern_decode.sv
// Purpose: classify a lamp pair as legal phase, illegal lamp code or conflicting pair.
// Latency: combinational.
// Backpressure: none.
module traffic_light_pattern_decode
    import traffic_light_pkg::*;
(
    input  logic [2:0] light_1,
    input  logic [2:0] light_2,
    output logic [1:0] phase,
    output logic       legal,
    output logic       illegal_code,
    output logic       conflict
);

    function automatic logic code_ok(input logic [2:0] c);
        return (c == LAMP_RED) || (c == LAMP_GREEN) || (c == LAMP_YELLOW);
    endfunction

    lamp_pair_t pat;
    assign pat = {light_1, light_2};

    always_comb begin
        phase        = P0;
        legal        = 1'b0;
        illegal_code = 1'b0;
        conflict     = 1'b0;
        if (!code_ok(light_1) || !code_ok(light_2)) begin
            illegal_code = 1'b1;
        end else begin
            case (pat)
                PAT_P0:  begin phase = P0; legal = 1'b1; end
                PAT_P1:  begin phase = P1; legal = 1'b1; end
                PAT_P2:  begin phase = P2; legal = 1'b1; end
                PAT_P3:  begin phase = P3; legal = 1'b1; end
                default: conflict = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Purpose: passive checker of lamp legality, phase order and phase dwell time.
// Latency: 2 cycles from lamp inputs to registered phase/error outputs.
// Backpressure: none; observes every cycle.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES
) (
    input  logic       clk,
    input  logic       rs,
    input  logic [2:0] light_1,
    input  logic [2:0] light_2,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic       err_illegal_code,
    output logic       err_conflict,
    output logic       err_sequence,
    output logic       err_timing,
    output logic       err_sticky,
    output logic [7:0] viol_count
);

    logic [2:0]  l1_q, l2_q;
    logic        s1_vld;
    lamp_pair_t  prev_pat;
    logic [7:0]  dwell;
    mon_state_t  state, state_nxt;

    logic [1:0]  dec_phase;
    logic        dec_legal, dec_illegal, dec_conflict;

    logic        changed;
    logic [7:0]  dwell_nxt, req_cur;
    logic [1:0]  phase_nxt;
    logic        valid_nxt;
    logic        e_ill, e_con, e_seq, e_tim, any_err;

    traffic_light_pattern_decode u_decode (
        .light_1      (l1_q),
        .light_2      (l2_q),
        .phase        (dec_phase),
        .legal        (dec_legal),
        .illegal_code (dec_illegal),
        .conflict     (dec_conflict)
    );

    // dwell==0 only right after reset, so the first observed pattern always starts a run.
    assign changed = (dwell == 8'd0) || ({l1_q, l2_q} != prev_pat);
    assign req_cur = req_dwell(phase, 8'(GREEN_CYCLES), 8'(YELLOW_CYCLES));

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        valid_nxt = phase_valid;
        e_ill     = 1'b0;
        e_con     = 1'b0;
        e_seq     = 1'b0;
        e_tim     = 1'b0;
        dwell_nxt = changed ? 8'd1 : ((dwell == 8'hFF) ? dwell : dwell + 8'd1);
        if (!dec_legal) begin
            e_ill     = dec_illegal && changed;
            e_con     = dec_conflict && changed;
            valid_nxt = 1'b0;
            state_nxt = SYNC;
        end else begin
            valid_nxt = 1'b1;
            phase_nxt = dec_phase;
            case (state)
                SYNC: state_nxt = FIRST;
                FIRST, TRACK: begin
                    if (changed) begin
                        e_seq     = (dec_phase != phase + 2'd1);
                        // The initial run may have started mid-phase, so it cannot be short.
                        e_tim     = (state == TRACK) && (dwell < req_cur);
                        state_nxt = TRACK;
                    end else begin
                        e_tim = (dwell == req_cur);
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
        any_err = e_ill | e_con | e_seq | e_tim;
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            l1_q             <= 3'd0;
            l2_q             <= 3'd0;
            s1_vld           <= 1'b0;
            prev_pat         <= '0;
            dwell            <= 8'd0;
            state            <= SYNC;
            phase            <= P0;
            phase_valid      <= 1'b0;
            err_illegal_code <= 1'b0;
            err_conflict     <= 1'b0;
            err_sequence     <= 1'b0;
            err_timing       <= 1'b0;
            err_sticky       <= 1'b0;
            viol_count       <= 8'd0;
        end else begin
            l1_q   <= light_1;
            l2_q   <= light_2;
            s1_vld <= 1'b1;
            if (s1_vld) begin
                prev_pat         <= {l1_q, l2_q};
                dwell            <= dwell_nxt;
                state            <= state_nxt;
                phase            <= phase_nxt;
                phase_valid      <= valid_nxt;
                err_illegal_code <= e_ill;
                err_conflict     <= e_con;
                err_sequence     <= e_seq;
                err_timing       <= e_tim;
                if (any_err) begin
                    err_sticky <= 1'b1;
                    if (viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed table-driven bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;
    import traffic_light_pkg::*;

    logic       clk = 1'b0;
    logic       rs  = 1'b1;
    logic [2:0] light_1, light_2;
    logic [1:0] phase;
    logic       phase_valid, err_illegal_code, err_conflict, err_sequence, err_timing, err_sticky;
    logic [7:0] viol_count;

    always #5 clk = ~clk;

    traffic_light_monitor #(.GREEN_CYCLES(16), .YELLOW_CYCLES(6)) dut (
        .clk              (clk),
        .rs               (rs),
        .light_1          (light_1),
        .light_2          (light_2),
        .phase            (phase),
        .phase_valid      (phase_valid),
        .err_illegal_code (err_illegal_code),
        .err_conflict     (err_conflict),
        .err_sequence     (err_sequence),
        .err_timing       (err_timing),
        .err_sticky       (err_sticky),
        .viol_count       (viol_count)
    );

    // One row = a lamp pair held for n cycles; pulse counts cover the n samples of that row.
    typedef struct {
        logic [2:0] l1;
        logic [2:0] l2;
        int         n;
        int         ph;
        int         vld;
        int         ill;
        int         con;
        int         seq;
        int         tim;
        int         tim_at;
        int         viol;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [2:0] G = LAMP_GREEN;
    localparam logic [2:0] R = LAMP_RED;
    localparam logic [2:0] Y = LAMP_YELLOW;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic [2:0] l1, input logic [2:0] l2, input int n,
                                input int ph, input int vld, input int ill, input int con,
                                input int seq, input int tim, input int tim_at, input int viol);
        vec_t v;
        v.l1 = l1; v.l2 = l2; v.n = n; v.ph = ph; v.vld = vld;
        v.ill = ill; v.con = con; v.seq = seq; v.tim = tim; v.tim_at = tim_at; v.viol = viol;
        tbl.push_back(v);
    endfunction

    task automatic run_row(input vec_t v, input string tag,
                           output logic [1:0] ph1, output logic [1:0] ph2);
        int ci = 0, cc = 0, cs = 0, ct = 0, tat = 0;
        ph1 = 2'd0;
        ph2 = 2'd0;
        light_1 = v.l1;
        light_2 = v.l2;
        for (int i = 1; i <= v.n; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) ph1 = phase;
            if (i == 2) ph2 = phase;
            ci += int'(err_illegal_code);
            cc += int'(err_conflict);
            cs += int'(err_sequence);
            ct += int'(err_timing);
            if (err_timing === 1'b1 && tat == 0) tat = i;
        end
        check($sformatf("%s illegal_pulses", tag), ci, v.ill);
        check($sformatf("%s conflict_pulses", tag), cc, v.con);
        check($sformatf("%s sequence_pulses", tag), cs, v.seq);
        check($sformatf("%s timing_pulses", tag), ct, v.tim);
        if (v.tim_at != 0) check($sformatf("%s timing_step", tag), tat, v.tim_at);
        check($sformatf("%s phase", tag), phase, v.ph);
        check($sformatf("%s phase_valid", tag), phase_valid, v.vld);
        check($sformatf("%s viol_count", tag), viol_count, v.viol);
        check($sformatf("%s err_sticky", tag), err_sticky, (v.viol != 0) ? 1 : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s phase", tag), phase, 0);
        check($sformatf("%s phase_valid", tag), phase_valid, 0);
        check($sformatf("%s err_illegal_code", tag), err_illegal_code, 0);
        check($sformatf("%s err_conflict", tag), err_conflict, 0);
        check($sformatf("%s err_sequence", tag), err_sequence, 0);
        check($sformatf("%s err_timing", tag), err_timing, 0);
        check($sformatf("%s err_sticky", tag), err_sticky, 0);
        check($sformatf("%s viol_count", tag), viol_count, 0);
    endtask

    initial begin
        logic [1:0] ph1, ph2;
        vec_t       stuck;

        light_1 = R;
        light_2 = R;
        rs      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rs = 1'b0;

        // Three clean controller cycles from reset.
        for (int k = 0; k < 3; k++) begin
            add(G, R, 16, 0, 1, 0, 0, 0, 0, 0, 0);
            add(Y, R,  6, 1, 1, 0, 0, 0, 0, 0, 0);
            add(R, G, 16, 2, 1, 0, 0, 0, 0, 0, 0);
            add(R, Y,  6, 3, 1, 0, 0, 0, 0, 0, 0);
        end
        add(G, R, 16, 0, 1, 0, 0, 0, 0, 0, 0);
        add(Y, R,  6, 1, 1, 0, 0, 0, 0, 0, 0);
        // Overrun: 17th P2 cycle is flagged 2 edges later, once only.
        add(R, G, 18, 2, 1, 0, 0, 0, 1, 18, 1);
        add(R, Y,  6, 3, 1, 0, 0, 0, 0, 0, 1);
        add(G, R, 16, 0, 1, 0, 0, 0, 0, 0, 1);
        // Short P1 run: flagged on the P1->P2 transition, no sequence error.
        add(Y, R,  4, 1, 1, 0, 0, 0, 0, 0, 1);
        add(R, G, 16, 2, 1, 0, 0, 0, 1, 2, 2);
        add(R, Y,  6, 3, 1, 0, 0, 0, 0, 0, 2);
        add(G, R, 16, 0, 1, 0, 0, 0, 0, 0, 2);
        // Skipped phase P0 -> P2, then clean continuation.
        add(R, G, 16, 2, 1, 0, 0, 1, 0, 0, 3);
        add(R, Y,  6, 3, 1, 0, 0, 0, 0, 0, 3);
        add(G, R, 16, 0, 1, 0, 0, 0, 0, 0, 3);
        add(Y, R,  6, 1, 1, 0, 0, 0, 0, 0, 3);
        // Illegal code, then conflict, then resync at P0 without sequence/timing errors.
        add(3'b011, R, 3, 1, 0, 1, 0, 0, 0, 0, 4);
        add(G, G,  2, 1, 0, 0, 1, 0, 0, 0, 5);
        add(G, R, 16, 0, 1, 0, 0, 0, 0, 0, 5);
        add(Y, R,  6, 1, 1, 0, 0, 0, 0, 0, 5);
        add(R, G, 16, 2, 1, 0, 0, 0, 0, 0, 5);
        add(R, Y,  6, 3, 1, 0, 0, 0, 0, 0, 5);
        add(G, R, 16, 0, 1, 0, 0, 0, 0, 0, 5);
        add(Y, R,  3, 1, 1, 0, 0, 0, 0, 0, 5);

        for (int r = 0; r < tbl.size(); r++) begin
            run_row(tbl[r], $sformatf("row%0d", r), ph1, ph2);
            if (r > 0 && tbl[r-1].vld == 1 && tbl[r].vld == 1) begin
                check($sformatf("row%0d latency_old_phase", r), ph1, tbl[r-1].ph);
                check($sformatf("row%0d latency_new_phase", r), ph2, tbl[r].ph);
            end
        end

        // Reset in the middle of P1 after errors clears everything.
        rs = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrun_reset");
        rs = 1'b0;

        // Stuck P0: dwell saturates but the overrun is reported only once.
        stuck.l1 = G; stuck.l2 = R; stuck.n = 300; stuck.ph = 0; stuck.vld = 1;
        stuck.ill = 0; stuck.con = 0; stuck.seq = 0; stuck.tim = 1; stuck.tim_at = 18; stuck.viol = 1;
        run_row(stuck, "stuck_p0", ph1, ph2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive observer on the two 3-bit lamp buses driven by the two-road traffic light controller.
- Registers and decodes both buses into a phase number.
- Checks three things: lamp codes are legal and non-conflicting, phases advance in order, and each phase dwells for the exact expected cycle count.
- Reports violations as one-cycle pulses, a sticky flag and a saturating counter, for use as a safety checker in simulation and on the board.

Parameters:
- GREEN_CYCLES, 16, required dwell of a green phase (P0, P2) in clk cycles; legal range 1..254.
- YELLOW_CYCLES, 6, required dwell of a yellow phase (P1, P3) in clk cycles; legal range 1..254.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rs  input  1  reset; synchronous, active-high.
- light_1  input  3  road-1 lamp code: 100 red, 010 green, 001 yellow.
- light_2  input  3  road-2 lamp code, same encoding.
- phase  output  2  decoded current phase: 0 = G/R, 1 = Y/R, 2 = R/G, 3 = R/Y.
- phase_valid  output  1  high while the registered pattern is one of the four legal phases.
- err_illegal_code  output  1  one-cycle pulse: a lamp code not in {100, 010, 001}.
- err_conflict  output  1  one-cycle pulse: both codes legal but the pair is not one of the four phases (e.g. both green, both red).
- err_sequence  output  1  one-cycle pulse: a legal phase was followed by a phase other than (prev+1) mod 4.
- err_timing  output  1  one-cycle pulse: phase dwell differs from its required value.
- err_sticky  output  1  set by any error pulse; cleared only by rs.
- viol_count  output  8  count of cycles carrying at least one error pulse; saturates at 255.

Behaviour:
- Reset (rs=1 at an edge): all outputs 0, input regs 0, state SYNC, dwell 0, prev phase cleared.
- Pipeline:
  - Stage 1: light_1/light_2 registered every cycle.
  - Stage 2: decode of the stage-1 values; all outputs registered from it.
  - An input change before edge N appears on the outputs after edge N+1 (2-cycle latency).
- Decode priority: illegal code > conflict > legal phase. The two error classes are mutually exclusive per cycle.
- dwell: 8-bit count of consecutive cycles the stage-1 pattern is unchanged; set to 1 on a change; saturates at 255.
- State SYNC:
  - Entered on reset or on any illegal/conflict pattern.
  - On the first legal pattern: set phase/phase_valid, go to FIRST.
  - No sequence or timing checks in SYNC.
- State FIRST (initial partial run):
  - Timing is checked only for overrun: dwell = required+1 gives err_timing.
  - On a change to a legal phase: run the sequence check, go to TRACK. No short-dwell check.
- State TRACK:
  - Overrun: at dwell = required+1, pulse err_timing, once per run.
  - On a change to a legal phase:
    - err_sequence if new != prev+1 mod 4.
    - err_timing if the completed run was shorter than required (dwell < required).
    - Both may pulse in the same cycle.
  - Stay in TRACK.
- Bad pattern (from any state):
  - phase_valid drops and phase holds its last value.
  - The error pulse fires only on the first cycle of a bad run; persistence is not re-flagged.
  - A change between two different bad patterns re-pulses.
  - Go to SYNC.
- viol_count increments by exactly 1 in any cycle where any err_* pulses, including simultaneous errors.
- rs mid-run discards all tracking. A controller restarting at P0 after reset therefore gives no sequence error.

Decomposition:
- Package traffic_light_pkg holds:
  - Lamp code constants LAMP_RED=100, LAMP_GREEN=010, LAMP_YELLOW=001.
  - Phase constants P0..P3 and the four legal pattern pairs.
  - Monitor state constants SYNC/FIRST/TRACK.
  - Default dwell values 16/6.
- One sub-module: traffic_light_pattern_decode. It is combinational and maps (light_1, light_2) to {phase, legal, illegal_code, conflict}; it is reused by the controller bench.

Test Plan:
- Drive a correct cycle from reset: P0 ×16, P1 ×6, P2 ×16, P3 ×6, repeated 3 times. Expect no err pulses, err_sticky=0, viol_count=0, phase tracking with 2-cycle latency.
- In TRACK, hold P2 for 18 cycles. Expect err_timing exactly once, 2 cycles after the 17th cycle sample, and viol_count=1.
- In TRACK, P1 lasts 4 cycles then P2. Expect err_timing together with no err_sequence on the transition cycle, and viol_count +1.
- Skip a phase, P0 → P2 (dwell correct). Expect err_sequence; drive P3 next, then expect clean tracking of the following cycle.
- Drive light_1=011 for 3 cycles, then (010, 010) for 2 cycles, then P0. Expect err_illegal_code once and err_conflict once, phase_valid=0, SYNC state with no timing/sequence error on resync, and viol_count=2.
- Assert rs for 1 cycle mid-P1 after errors. Expect all outputs 0 and err_sticky cleared; a 300-cycle stuck P0 afterward saturates dwell with a single err_timing pulse.
